// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared types and constants for the AHB-to-APB bridge controller
package bridge_pkg;

    // Error states exist only when BRIDGE_ERROR_RESP_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_SETUP,
        ST_ENABLE
`ifdef BRIDGE_ERROR_RESP_EN
        ,
        ST_ERR1,
        ST_ERR2
`endif
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Each APB slave owns a 64 MiB window
    localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
    localparam logic [31:0] SLV_MASK  = 32'hFC00_0000;

endpackage

// File: rtl/bridge_addr_decode.sv
// rtl/bridge_addr_decode.sv - combinational AHB address to APB slave select decode
module bridge_addr_decode
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              mapped,
    output logic [2:0]        sel
);

    logic [31:0] addr32;

    // Match the upper address bits against each slave window
    always_comb begin
        addr32 = 32'(addr);
        sel[0] = ((addr32 & SLV_MASK) == SLV0_BASE);
        sel[1] = ((addr32 & SLV_MASK) == SLV1_BASE);
        sel[2] = ((addr32 & SLV_MASK) == SLV2_BASE);
        mapped = |sel;
    end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// rtl/apb_bridge_ctrl.sv - AHB-slave-side APB bridge FSM; optional BRIDGE_ERROR_RESP_EN adds ERROR response
module apb_bridge_ctrl
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Hresetn,
    input  logic [1:0]        Htrans,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic [2:0]        Pselx,
    output logic              Pwrite,
    output logic              Penable
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [2:0]          sel_q, sel_d;
    logic [2:0]          pselx_q, pselx_d;
    logic                penable_q, penable_d;
    logic                hreadyout_q, hreadyout_d;
    logic [1:0]          hresp_q, hresp_d;
    logic                valid;
    logic                dec_mapped;
    logic [2:0]          dec_sel;

    bridge_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
        .addr   (Haddr),
        .mapped (dec_mapped),
        .sel    (dec_sel)
    );

    // Next state, capture of the address phase, then outputs decoded from next state
    always_comb begin
        valid    = Hreadyin && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        sel_d    = sel_q;
        case (state_q)
            ST_WWAIT: begin
                state_d  = ST_SETUP;
                pwdata_d = Hwdata;
            end
            ST_SETUP: state_d = ST_ENABLE;
`ifdef BRIDGE_ERROR_RESP_EN
            ST_ERR1:  state_d = ST_ERR2;
`endif
            // ST_IDLE, ST_ENABLE and ST_ERR2 all accept a new address phase
            default: begin
                state_d = ST_IDLE;
                if (valid) begin
                    paddr_d  = Haddr;
                    pwrite_d = Hwrite;
                    sel_d    = dec_sel;
                    if (dec_mapped) begin
                        state_d = Hwrite ? ST_WWAIT : ST_SETUP;
                    end else begin
`ifdef BRIDGE_ERROR_RESP_EN
                        state_d = ST_ERR1;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
        endcase

        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        case (state_d)
            ST_WWAIT: hreadyout_d = 1'b0;
            ST_SETUP: begin
                pselx_d     = sel_d;
                hreadyout_d = 1'b0;
            end
            ST_ENABLE: begin
                pselx_d   = sel_d;
                penable_d = 1'b1;
            end
`ifdef BRIDGE_ERROR_RESP_EN
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end
            ST_ERR2: hresp_d = HRESP_ERROR;
`endif
            default: ;
        endcase
    end

    // State and registered outputs; reset abandons any APB transfer in flight
    always_ff @(posedge clk) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            sel_q       <= 3'b000;
            pselx_q     <= 3'b000;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            sel_q       <= sel_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Read data passes straight through only during a read ENABLE cycle
    always_comb begin
        Hrdata = (state_q == ST_ENABLE && !pwrite_q) ? Prdata : '0;
    end

    assign Hreadyout = hreadyout_q;
    assign Hresp     = hresp_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pselx     = pselx_q;
    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;

endmodule

// File: doc/apb_bridge_ctrl.md
# apb_bridge_ctrl

AHB-slave-side controller of the AHB-to-APB bridge. Samples AHB address phases, decodes them onto three APB slave selects, and runs the APB SETUP/ENABLE sequence. Stretches the AHB data phase through Hreadyout until the APB transfer completes. It consumes the signals the AHB driver places on the bus and produces Hreadyout/Hrdata/Hresp back to it, plus the APB bus.

## Interface
Parameters:
- ADDR_W, 32, AHB/APB address width
- DATA_W, 32, AHB/APB data width

Ports:
- clk  in  1  bridge clock
- Hresetn  in  1  reset; one clock; synchronous, active-low
- Htrans  in  2  AHB transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
- Hwrite  in  1  1 = write
- Hreadyin  in  1  AHB HREADY seen by this slave
- Haddr  in  ADDR_W  address-phase address
- Hwdata  in  DATA_W  write data, valid in the cycle after the write address phase
- Prdata  in  DATA_W  APB read data
- Hreadyout  out  1  data-phase completion to AHB
- Hresp  out  2  00 OKAY, 01 ERROR
- Hrdata  out  DATA_W  read data to AHB
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Pselx  out  3  one-hot APB slave select
- Pwrite  out  1  APB direction
- Penable  out  1  APB enable

## Operation
- Map: slave0 0x8000_0000–0x83FF_FFFF, slave1 0x8400_0000–0x87FF_FFFF, slave2 0x8800_0000–0x8BFF_FFFF; anything else unmapped.
- valid = Hreadyin & Htrans[1] (NONSEQ/SEQ). BUSY/IDLE are never valid. Hsize/Hburst are not used.
- Accept: valid at a rising edge while state ∈ {ST_IDLE, ST_ENABLE, ST_ERR2}. Haddr, Hwrite and decoded select are captured on accept.
- FSM states: ST_IDLE, ST_WWAIT, ST_SETUP, ST_ENABLE, ST_ERR1, ST_ERR2.
- Transitions:
  - ST_IDLE/ST_ENABLE/ST_ERR2 → ST_SETUP on accepted mapped read.
  - Same states → ST_WWAIT on accepted mapped write.
  - Same states → ST_IDLE otherwise, including unmapped handling per Configuration.
  - ST_WWAIT → ST_SETUP unconditionally; Hwdata is captured into Pwdata on this edge.
  - ST_SETUP → ST_ENABLE unconditionally.
- Outputs are registered from next-state, except Hrdata:
  - ST_SETUP: Pselx = captured select, Penable 0, Hreadyout 0.
  - ST_ENABLE: Pselx held, Penable 1, Hreadyout 1.
  - ST_WWAIT: Pselx 0, Penable 0, Hreadyout 0.
  - ST_IDLE: Pselx 0, Penable 0, Hreadyout 1.
- Paddr/Pwrite hold the captured values until the next accept.
- Hrdata = Prdata when state == ST_ENABLE and !Pwrite, else 0 (combinational).
- Back-to-back: accepting in ST_ENABLE goes straight to ST_SETUP/ST_WWAIT. The APB bus never sees Psel drop between transfers to consecutive reads.

## Timing
- Reset (Hresetn low at an edge):
  - State → ST_IDLE.
  - Hreadyout 1, Hresp 00.
  - Pselx 0, Penable 0, Pwrite 0, Paddr 0, Pwdata 0.
  - Reset mid-transfer abandons the APB transfer at that edge; no ENABLE is issued.
- Read, accepted at edge N: SETUP in cycle N..N+1, ENABLE in N+1..N+2 with Hreadyout 1. The AHB data phase has exactly 1 wait state.
- Write, accepted at edge N: WWAIT in cycle N..N+1 (Hwdata sampled at N+1), SETUP in N+1..N+2, ENABLE in N+2..N+3. The data phase has exactly 2 wait states.
- Hresp is 00 in every state except ST_ERR1/ST_ERR2.

## Configuration
- BRIDGE_ERROR_RESP_EN defined: an accepted unmapped transfer → ST_ERR1 (Hreadyout 0, Hresp 01), then ST_ERR2 (Hreadyout 1, Hresp 01). Pselx stays 0 throughout. ST_ERR2 accepts a new transfer like ST_ENABLE.
- Undefined: unmapped transfers are ignored. State stays/returns to ST_IDLE, Hreadyout 1, Hresp 00, and no APB activity occurs. ST_ERR1/ST_ERR2 are not compiled.

## Structure
- Package bridge_pkg holds:
  - state enum;
  - HTRANS_* and HRESP_* constants;
  - slave base/mask constants (SLV0_BASE … , SLV_MASK 0xFC00_0000).
- Sub-module bridge_addr_decode: combinational Haddr → {mapped, sel[2:0]}, instantiated once.

## Test plan
- Reset: hold Hresetn low 2 cycles, then release → Hreadyout 1, Hresp 00, Pselx 000, Penable 0, Paddr 0.
- Single read, Haddr 0x8000_0010, NONSEQ, Prdata 0xDEAD_BEEF → Pselx 001 for 2 cycles, Penable in the 2nd cycle only. Hreadyout 0 then 1. Hrdata 0xDEAD_BEEF in the ENABLE cycle.
- Single write, Haddr 0x8400_0004, Hwdata 0x1234_5678 → WWAIT with Pselx 000, then Pselx 010, Pwrite 1, Pwdata 0x1234_5678. Hreadyout low for 2 cycles.
- Back-to-back reads to 0x8800_0000 and 0x8800_0004 (second accepted during ENABLE) → Pselx 100 continuous, Paddr updates, Penable toggles 0,1,0,1.
- Htrans BUSY or Hreadyin 0 with a mapped address → no state change, Pselx 000.
- Unmapped 0x9000_0000: with BRIDGE_ERROR_RESP_EN → Hresp 01 for 2 cycles, Hreadyout 0 then 1. Without it → Hresp 00, Hreadyout 1, no Psel.
